// File: rtl/rv_pkg.sv
// Shared RV32I definitions: major opcodes, funct3 encodings and a clog2 helper.
package rv_pkg;

    typedef enum logic [6:0] {
        OPC_R    = 7'b0110011,
        OPC_I    = 7'b0010011,
        OPC_L    = 7'b0000011,
        OPC_S    = 7'b0100011,
        OPC_B    = 7'b1100011,
        OPC_J    = 7'b1101111,
        OPC_JALR = 7'b1100111,
        OPC_HLT  = 7'b1010101
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_alu_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_br_e;

    // Elaboration-time ceil(log2(n)); returns 0 for n <= 1.
    function automatic int rv_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rv_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, EX redirect, decode handshake, halt flag.
interface rv_fetch_unit_if #(
    parameter int PC_W = 10,
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_ir;
    logic [PC_W-1:0] out_pc;
    logic [PC_W-1:0] out_npc;
    logic            halted;

    // The fetch unit itself.
    modport master (
        output imem_req, imem_addr, out_valid, out_ir, out_pc, out_npc, halted,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    // Memory, EX and decode side as seen from outside the fetch unit.
    modport slave (
        input  imem_req, imem_addr, out_valid, out_ir, out_pc, out_npc, halted,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/rv_fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush, head word readable without a pop.
module rv_fetch_fifo
    import rv_pkg::*;
#(
    parameter int W      = 42,
    parameter int QDEPTH = 4,
    localparam int AW    = rv_clog2(QDEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [W-1:0]  r_mem [QDEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(QDEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full queue is fine when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_count   = r_count;
    // Head entry drives the consumer directly so a word is visible the cycle after its write.
    assign o_rdata   = r_mem[r_rd_ptr];

    // Pointer and occupancy update; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (srst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage array, no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// RV32I fetch stage: PC sequencing, one-deep in-flight tracking, redirect flush and HLT stop.
module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [6:0]      HLT_OP   = OPC_HLT
) (
    input logic             clk,
    input logic             start,
    rv_fetch_unit_if.master bus
);
    localparam int AW = rv_clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + XLEN;

    logic [PC_W-1:0] r_pc;
    logic            r_inflight;
    logic [PC_W-1:0] r_inflight_pc;
    logic            r_halted;

    logic [EW-1:0]   w_head;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_occ;
    logic            w_full;
    logic            w_empty;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_hlt_in;
    logic [PC_W-1:0] w_head_pc;

    // Queued words plus the one still in memory must fit, so the queue can never overflow.
    assign w_occ   = w_count + CW'(r_inflight);
    assign w_issue = !start && !r_halted && !bus.redirect_valid && !w_full
                     && (w_occ < CW'(QDEPTH));

    // Requests are never issued in a redirect cycle, and a redirect in the return cycle
    // clears r_inflight, so r_inflight doubles as the epoch tag: a set flag with no
    // redirect now means the word belongs to the current path. Words issued in the
    // same cycle an HLT was enqueued come back while halted and are discarded.
    assign w_push   = r_inflight && !bus.redirect_valid && !r_halted && !start;
    assign w_pop    = !w_empty && bus.out_ready;
    assign w_hlt_in = w_push && (bus.imem_rdata[6:0] == HLT_OP);

    rv_fetch_fifo #(
        .W      (EW),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (start),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_wdata ({r_inflight_pc, bus.imem_rdata}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Fetch PC, in-flight tracking and halt flag; start beats redirect, redirect beats HLT.
    always_ff @(posedge clk) begin
        if (start) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_halted      <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc       <= bus.redirect_pc;
            r_inflight <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + PC_W'(1);
                r_inflight_pc <= r_pc;
            end
            if (w_hlt_in) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign w_head_pc     = w_head[EW-1:XLEN];
    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = r_pc;
    assign bus.halted    = r_halted;
    assign bus.out_valid = !w_empty;
    // Zero the payload when nothing is valid so idle outputs are deterministic.
    assign bus.out_ir    = w_empty ? '0 : w_head[XLEN-1:0];
    assign bus.out_pc    = w_empty ? '0 : w_head_pc;
    assign bus.out_npc   = w_empty ? '0 : (w_head_pc + PC_W'(1));

endmodule
